// File: rtl/inc_count_ctrl_if.sv
// Control/status bundle for the inc_count_ctrl counter stage.
// The master drives the controls and observes count/status; the counter is the slave.
interface inc_count_ctrl_if;
  logic       start;
  logic       stop;
  logic       oneShot;
  logic       en;
  logic       load;
  logic [3:0] loadVal;
  logic [3:0] count;
  logic       terminal;
  logic       done;
  logic       busy;

  modport master (
    output start, stop, oneShot, en, load, loadVal,
    input  count, terminal, done, busy
  );

  modport slave (
    input  start, stop, oneShot, en, load, loadVal,
    output count, terminal, done, busy
  );
endinterface

// File: rtl/inc_count_ctrl.sv
// Registered 4-bit counter stage feeding a +1 ripple incrementer.
// Adds a modulus limit (MAXVAL), a synchronous load and an IDLE/RUN/DONE
// control FSM selecting free-run wrap or one-shot stop at the limit.

// 4-bit ripple incrementer with carry-in fixed at 1.
module inc_count_ctrl_inc4 (
  input  logic [3:0] a,
  output logic [3:0] sum,
  output logic       carry_out
);
  logic [4:0] carry_s;

  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]         = a[i] ^ carry_s[i];
    assign carry_s[i + 1] = a[i] & carry_s[i];
  end

  assign carry_out = carry_s[4];
endmodule

// Run-time invariants of the counter outputs.
module inc_count_ctrl_chk #(
  parameter logic [3:0] MAXVAL = 4'd15
) (
  input logic       clk,
  input logic       rst,
  input logic [3:0] count,
  input logic       terminal,
  input logic       done,
  input logic       busy
);
  // RUN and DONE are mutually exclusive states.
  a_busy_done_excl : assert property (@(posedge clk) disable iff (rst)
    !(busy && done));

  // terminal is a pulse: a wrap can never be followed directly by another.
  a_term_pulse : assert property (@(posedge clk) disable iff (rst)
    terminal |=> !terminal);

  // A pulse comes with either a wrapped count in RUN or a held limit in DONE.
  a_term_value : assert property (@(posedge clk) disable iff (rst)
    terminal |-> ((busy && (count == 4'd0)) ||
                  (done && ((count == MAXVAL) || (count == 4'd15)))));
endmodule

// Counter stage top level.
module inc_count_ctrl #(
  parameter logic [3:0] MAXVAL = 4'd15
) (
  input  logic             clk,
  input  logic             rst,
  inc_count_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       terminal_q, terminal_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [3:0] inc_sum_s;
  logic       inc_carry_s;
  logic       at_limit_s;
  logic       wrap_s;

  inc_count_ctrl_inc4 u_inc (
    .a         (count_q),
    .sum       (inc_sum_s),
    .carry_out (inc_carry_s)
  );

  assign at_limit_s = (count_q == MAXVAL);

  // Wrap event: limit reached or incrementer overflow, only on a plain enabled RUN edge.
  // The carry term catches loaded values above MAXVAL that run through 15.
  always_comb begin
    wrap_s = 1'b0;
    if ((state_q == ST_RUN) && bus.en && !bus.load && !bus.stop) begin
      wrap_s = at_limit_s | inc_carry_s;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Next state and next count, priority stop > load > start > en.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    terminal_d = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
    end else if (bus.load) begin
      count_d = bus.loadVal;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!bus.en) begin
            count_d = count_q;
          end else if (wrap_s) begin
            terminal_d = 1'b1;
            if (bus.oneShot) begin
              state_d = ST_DONE;
            end else begin
              count_d = 4'd0;
            end
          end else begin
            count_d = inc_sum_s;
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            count_d = 4'd0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they track it glitch-free.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, count and status registers; reset discards all progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= 4'd0;
      terminal_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      terminal_q <= terminal_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.terminal = terminal_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  inc_count_ctrl_chk #(.MAXVAL(MAXVAL)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .count    (count_q),
    .terminal (terminal_q),
    .done     (done_q),
    .busy     (busy_q)
  );
endmodule

// File: tb/tb_inc_count_ctrl.sv
// Directed bench for inc_count_ctrl: four instances with MAXVAL 15, 9, 5 and 1.
module tb_inc_count_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  inc_count_ctrl_if b15 ();
  inc_count_ctrl_if b9 ();
  inc_count_ctrl_if b5 ();
  inc_count_ctrl_if b1 ();

  inc_count_ctrl #(.MAXVAL(4'd15)) u15 (.clk(clk), .rst(rst), .bus(b15));
  inc_count_ctrl #(.MAXVAL(4'd9))  u9  (.clk(clk), .rst(rst), .bus(b9));
  inc_count_ctrl #(.MAXVAL(4'd5))  u5  (.clk(clk), .rst(rst), .bus(b5));
  inc_count_ctrl #(.MAXVAL(4'd1))  u1  (.clk(clk), .rst(rst), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (b15.count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", b15.count); end
    checks++; if (b15.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", b15.busy); end
    checks++; if (b15.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", b15.done); end
    checks++; if (b15.terminal !== 1'b0) begin failures++; $display("FAIL rst_term got=%0b exp=0", b15.terminal); end
    b15.start = 1'b1;
    tick();
    b15.start = 1'b0;
    checks++; if (b15.busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%0b exp=1", b15.busy); end
    b15.en = 1'b1;
    repeat (7) tick();
    checks++; if (b15.count !== 4'd7) begin failures++; $display("FAIL run_count7 got=%0d exp=7", b15.count); end
    // Asynchronous reset mid-cycle, no clock edge in between.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (b15.count !== 4'd0) begin failures++; $display("FAIL async_rst_count got=%0d exp=0", b15.count); end
    checks++; if (b15.busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%0b exp=0", b15.busy); end
    checks++; if (b15.done !== 1'b0) begin failures++; $display("FAIL async_rst_done got=%0b exp=0", b15.done); end
    checks++; if (b15.terminal !== 1'b0) begin failures++; $display("FAIL async_rst_term got=%0b exp=0", b15.terminal); end
    b15.en = 1'b0;
    rst = 1'b0;
    tick();
    b15.start = 1'b1;
    tick();
    b15.start = 1'b0;
    checks++; if (b15.busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%0b exp=1", b15.busy); end
    b15.en = 1'b1;
    repeat (3) tick();
    b15.en = 1'b0;
    checks++; if (b15.count !== 4'd3) begin failures++; $display("FAIL restart_count3 got=%0d exp=3", b15.count); end
  endtask

  task automatic test_maxval15_single();
    b15.load = 1'b1;
    b15.loadVal = 4'd14;
    tick();
    b15.load = 1'b0;
    checks++; if (b15.count !== 4'd14) begin failures++; $display("FAIL m15_load got=%0d exp=14", b15.count); end
    checks++; if (b15.busy !== 1'b1) begin failures++; $display("FAIL m15_load_busy got=%0b exp=1", b15.busy); end
    b15.en = 1'b1;
    tick();
    checks++; if (b15.count !== 4'd15 || b15.terminal !== 1'b0) begin failures++; $display("FAIL m15_c15 got=%0d/%0b exp=15/0", b15.count, b15.terminal); end
    tick();
    checks++; if (b15.count !== 4'd0 || b15.terminal !== 1'b1) begin failures++; $display("FAIL m15_wrap got=%0d/%0b exp=0/1", b15.count, b15.terminal); end
    tick();
    checks++; if (b15.count !== 4'd1 || b15.terminal !== 1'b0) begin failures++; $display("FAIL m15_after got=%0d/%0b exp=1/0", b15.count, b15.terminal); end
    b15.en = 1'b0;
  endtask

  task automatic test_free_run();
    logic [3:0] exp_cnt [12];
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    b9.oneShot = 1'b0;
    b9.start = 1'b1;
    tick();
    b9.start = 1'b0;
    b9.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (b9.count !== exp_cnt[i]) begin failures++; $display("FAIL fr_count[%0d] got=%0d exp=%0d", i, b9.count, exp_cnt[i]); end
      checks++; if (b9.terminal !== (i == 9)) begin failures++; $display("FAIL fr_term[%0d] got=%0b exp=%0b", i, b9.terminal, (i == 9)); end
      checks++; if (b9.busy !== 1'b1) begin failures++; $display("FAIL fr_busy[%0d] got=%0b exp=1", i, b9.busy); end
    end
    b9.en = 1'b0;
    b9.stop = 1'b1;
    tick();
    b9.stop = 1'b0;
    checks++; if (b9.busy !== 1'b0 || b9.count !== 4'd2) begin failures++; $display("FAIL fr_stop got=%0b/%0d exp=0/2", b9.busy, b9.count); end
  endtask

  task automatic test_one_shot();
    b5.oneShot = 1'b1;
    b5.start = 1'b1;
    tick();
    b5.start = 1'b0;
    b5.en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (b5.count !== 4'(i) || b5.terminal !== 1'b0 || b5.busy !== 1'b1) begin
        failures++; $display("FAIL os_count[%0d] got=%0d/%0b/%0b exp=%0d/0/1", i, b5.count, b5.terminal, b5.busy, i);
      end
    end
    tick();
    checks++; if (b5.count !== 4'd5) begin failures++; $display("FAIL os_done_count got=%0d exp=5", b5.count); end
    checks++; if (b5.terminal !== 1'b1) begin failures++; $display("FAIL os_done_term got=%0b exp=1", b5.terminal); end
    checks++; if (b5.done !== 1'b1 || b5.busy !== 1'b0) begin failures++; $display("FAIL os_done_flags got=%0b/%0b exp=1/0", b5.done, b5.busy); end
    b5.oneShot = 1'b0;
    tick();
    checks++; if (b5.count !== 4'd5 || b5.terminal !== 1'b0 || b5.done !== 1'b1) begin
      failures++; $display("FAIL os_hold got=%0d/%0b/%0b exp=5/0/1", b5.count, b5.terminal, b5.done);
    end
    b5.en = 1'b0;
    b5.start = 1'b1;
    tick();
    b5.start = 1'b0;
    checks++; if (b5.count !== 4'd0 || b5.busy !== 1'b1 || b5.done !== 1'b0) begin
      failures++; $display("FAIL os_restart got=%0d/%0b/%0b exp=0/1/0", b5.count, b5.busy, b5.done);
    end
    b5.stop = 1'b1;
    tick();
    b5.stop = 1'b0;
  endtask

  task automatic test_load_beyond();
    b9.oneShot = 1'b1;
    b9.load = 1'b1;
    b9.loadVal = 4'd13;
    tick();
    b9.load = 1'b0;
    checks++; if (b9.count !== 4'd13 || b9.busy !== 1'b0) begin failures++; $display("FAIL lb_load got=%0d/%0b exp=13/0", b9.count, b9.busy); end
    b9.start = 1'b1;
    tick();
    b9.start = 1'b0;
    checks++; if (b9.count !== 4'd13 || b9.busy !== 1'b1) begin failures++; $display("FAIL lb_start got=%0d/%0b exp=13/1", b9.count, b9.busy); end
    b9.en = 1'b1;
    tick();
    checks++; if (b9.count !== 4'd14) begin failures++; $display("FAIL lb_c14 got=%0d exp=14", b9.count); end
    tick();
    checks++; if (b9.count !== 4'd15 || b9.terminal !== 1'b0) begin failures++; $display("FAIL lb_c15 got=%0d/%0b exp=15/0", b9.count, b9.terminal); end
    tick();
    checks++; if (b9.count !== 4'd15 || b9.terminal !== 1'b1 || b9.done !== 1'b1) begin
      failures++; $display("FAIL lb_done got=%0d/%0b/%0b exp=15/1/1", b9.count, b9.terminal, b9.done);
    end
    b9.en = 1'b0;
    b9.load = 1'b1;
    b9.loadVal = 4'd4;
    tick();
    b9.load = 1'b0;
    checks++; if (b9.count !== 4'd4 || b9.done !== 1'b0 || b9.busy !== 1'b0) begin
      failures++; $display("FAIL lb_done_load got=%0d/%0b/%0b exp=4/0/0", b9.count, b9.done, b9.busy);
    end
  endtask

  task automatic test_priority();
    b9.oneShot = 1'b0;
    b9.start = 1'b1;
    tick();
    b9.start = 1'b0;
    checks++; if (b9.count !== 4'd4 || b9.busy !== 1'b1) begin failures++; $display("FAIL pr_run got=%0d/%0b exp=4/1", b9.count, b9.busy); end
    b9.load = 1'b1;
    b9.loadVal = 4'd2;
    b9.en = 1'b1;
    b9.start = 1'b1;
    tick();
    b9.en = 1'b0;
    b9.start = 1'b0;
    checks++; if (b9.count !== 4'd2 || b9.busy !== 1'b1 || b9.terminal !== 1'b0) begin
      failures++; $display("FAIL pr_load got=%0d/%0b/%0b exp=2/1/0", b9.count, b9.busy, b9.terminal);
    end
    b9.stop = 1'b1;
    b9.loadVal = 4'd7;
    tick();
    b9.stop = 1'b0;
    b9.load = 1'b0;
    checks++; if (b9.count !== 4'd2 || b9.busy !== 1'b0 || b9.done !== 1'b0) begin
      failures++; $display("FAIL pr_stop got=%0d/%0b/%0b exp=2/0/0", b9.count, b9.busy, b9.done);
    end
  endtask

  task automatic test_gated_max1();
    logic       en_pat [4];
    logic [3:0] exp_cnt [4];
    logic       exp_term [4];
    en_pat   = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_cnt  = '{4'd1, 4'd1, 4'd0, 4'd0};
    exp_term = '{1'b0, 1'b0, 1'b1, 1'b0};
    b1.oneShot = 1'b0;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b1.en = en_pat[i];
      tick();
      checks++; if (b1.count !== exp_cnt[i] || b1.terminal !== exp_term[i]) begin
        failures++; $display("FAIL m1_gated[%0d] got=%0d/%0b exp=%0d/%0b", i, b1.count, b1.terminal, exp_cnt[i], exp_term[i]);
      end
    end
    b1.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (b1.count !== 4'(i % 2 == 0 ? 1 : 0) || b1.terminal !== (i % 2 == 1)) begin
        failures++; $display("FAIL m1_held[%0d] got=%0d/%0b exp=%0d/%0b", i, b1.count, b1.terminal, (i % 2 == 0 ? 1 : 0), (i % 2 == 1));
      end
    end
    b1.en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    b15.start = 1'b0; b15.stop = 1'b0; b15.oneShot = 1'b0; b15.en = 1'b0; b15.load = 1'b0; b15.loadVal = 4'd0;
    b9.start  = 1'b0; b9.stop  = 1'b0; b9.oneShot  = 1'b0; b9.en  = 1'b0; b9.load  = 1'b0; b9.loadVal  = 4'd0;
    b5.start  = 1'b0; b5.stop  = 1'b0; b5.oneShot  = 1'b0; b5.en  = 1'b0; b5.load  = 1'b0; b5.loadVal  = 4'd0;
    b1.start  = 1'b0; b1.stop  = 1'b0; b1.oneShot  = 1'b0; b1.en  = 1'b0; b1.load  = 1'b0; b1.loadVal  = 4'd0;
    test_reset();
    test_maxval15_single();
    test_free_run();
    test_one_shot();
    test_load_beyond();
    test_priority();
    test_gated_max1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
